// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Fetch stage sitting between a combinational instruction ROM and decode.
// Holds the PC, drives the ROM address and chip enable, captures each returned
// word together with its PC into a small FIFO, and presents the FIFO head to
// decode over a valid/ready handshake. A branch flushes the FIFO and reloads
// the PC with the word-aligned target.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   inst_rom_addr_o  ROM byte address (current PC)
//   inst_rom_ce_o    ROM chip enable (run flag, set one edge after reset)
//   inst_rom_data_i  ROM data, valid in the same cycle as the address
//   branch_flag_i    redirect request
//   branch_target_i  redirect PC (low two bits ignored)
//   id_ready_i       decode accepts the head entry this cycle
//   if_valid_o       head entry valid
//   if_inst_o        head instruction (0 when empty)
//   if_pc_o          PC of head instruction (0 when empty)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] inst_rom_addr_o,
    output logic        inst_rom_ce_o,
    input  logic [31:0] inst_rom_data_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          ce_r;
    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [31:0]   fifo_pc_r   [FIFO_DEPTH];
    logic [31:0]   fifo_inst_r [FIFO_DEPTH];

    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic          flush_s;

    // Handshake and fetch qualifiers; a pop frees a slot so a full FIFO can still accept
    always_comb begin
        valid_s = (count_r != {CW{1'b0}});
        pop_s   = valid_s & id_ready_i;
        flush_s = ce_r & branch_flag_i;
        push_s  = ce_r & ((count_r < DEPTH_C) | pop_s) & ~branch_flag_i;
    end

    // Run flag and PC; branch only takes effect once the run flag is set
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ce_r <= 1'b0;
            pc_r <= RESET_PC;
        end else if (!ce_r) begin
            ce_r <= 1'b1;
            pc_r <= pc_r;
        end else if (branch_flag_i) begin
            ce_r <= 1'b1;
            pc_r <= branch_target_i & 32'hFFFF_FFFC;
        end else if (push_s) begin
            ce_r <= 1'b1;
            pc_r <= pc_r + 32'd4;
        end else begin
            ce_r <= 1'b1;
            pc_r <= pc_r;
        end
    end

    // FIFO pointers and occupancy; a flush overrides any coincident push or pop
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush_s) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r <= pop_s  ? head_r + PTR_ONE : head_r;
            tail_r <= push_s ? tail_r + PTR_ONE : tail_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: capture the PC with the ROM word fetched from it
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]   <= 32'h0000_0000;
                fifo_inst_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_pc_r[tail_r]   <= pc_r;
            fifo_inst_r[tail_r] <= inst_rom_data_i;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]   <= fifo_pc_r[i];
                fifo_inst_r[i] <= fifo_inst_r[i];
            end
        end
    end

    // Head presentation; zeroed when empty so decode never sees stale entries
    always_comb begin
        if (valid_s) begin
            if_inst_o = fifo_inst_r[head_r];
            if_pc_o   = fifo_pc_r[head_r];
        end else begin
            if_inst_o = 32'h0000_0000;
            if_pc_o   = 32'h0000_0000;
        end
    end

    assign if_valid_o      = valid_s;
    assign inst_rom_addr_o = pc_r;
    assign inst_rom_ce_o   = ce_r;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that drives the instruction ROM.
- Holds the PC and issues address plus chip-enable to the combinational instruction ROM.
- Captures each returned word with its PC into a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Redirects on branch by flushing buffered instructions and reloading the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
FIFO_DEPTH, 2, entries in the fetch buffer; power of two, >= 2.

Ports:
clk_i  input  1  clock, rising edge.
rst_n_i  input  1  reset, asynchronous, active-low.
inst_rom_addr_o  output  32  byte address to ROM; equals current PC register.
inst_rom_ce_o  output  1  ROM chip enable; registered run flag.
inst_rom_data_i  input  32  ROM read data, valid combinationally in the same cycle as inst_rom_addr_o.
branch_flag_i  input  1  redirect request, sampled at clock edge.
branch_target_i  input  32  redirect PC.
id_ready_i  input  1  decode accepts head instruction this cycle.
if_valid_o  output  1  head entry valid.
if_inst_o  output  32  head instruction; 0 when empty.
if_pc_o  output  32  PC of head instruction; 0 when empty.

Behaviour:
- Reset (rst_n_i low, async, immediate):
  - pc = RESET_PC, ce = 0, FIFO count = 0.
  - if_valid_o = 0, if_inst_o = 0, if_pc_o = 0.
  - inst_rom_addr_o = RESET_PC, inst_rom_ce_o = 0.
- Startup:
  - On the first rising edge after rst_n_i releases: ce <= 1 and pc is unchanged.
  - ce stays 1 until the next reset.
- Definitions:
  - push = ce & (count < FIFO_DEPTH | pop) & ~branch_flag_i.
  - pop = if_valid_o & id_ready_i.
- Fetch, on each edge with push = 1:
  - Write {pc, inst_rom_data_i} at the tail.
  - pc <= pc + 4, 32-bit wrap, so 0xFFFF_FFFC -> 0x0000_0000.
- Hold: when push = 0 and there is no branch, pc holds and inst_rom_addr_o is stable.
- Latency: the word at address A appears on if_inst_o one cycle after A is driven on inst_rom_addr_o, when the FIFO was empty.
- Output:
  - if_valid_o = (count != 0); if_inst_o and if_pc_o show the head entry, combinational from FIFO storage.
  - Pop advances the head.
  - Push and pop together leave count unchanged; this is allowed when full.
- Branch (branch_flag_i = 1 at an edge, only effective when ce = 1):
  - FIFO cleared, count = 0.
  - pc <= {branch_target_i[31:2], 2'b00}; misaligned low bits are dropped.
  - No push that edge.
  - Any coincident pop is discarded with the flush.
  - Branch has priority over push and pop.
  - The next cycle drives the target address; the target instruction is valid one cycle later.
- Branch during startup: branch_flag_i while ce = 0 is ignored.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH. There is no overflow or underflow path.
- Empty read: if_inst_o and if_pc_o are forced to 0 when empty, never stale data.
- Reset mid-operation:
  - All state is cleared asynchronously; in-flight entries are lost.
  - Fetch restarts from RESET_PC following the startup rule.

Test Plan:
1. Reset then release with id_ready_i = 1 and ROM[i] = 0x1000_0000 + i -> ce rises on edge 1; from edge 2, if_pc_o / if_inst_o step 0x0 / 0x10000000, 0x4 / 0x10000001, 0x8 / 0x10000002, one per cycle.
2. Backpressure: id_ready_i = 0 from start -> two pushes, then count = 2 and inst_rom_addr_o holds 0x8 while if_pc_o holds 0x0. Raise ready for one cycle -> if_pc_o = 0x4 and addr advances to 0xC.
3. Branch while full: branch_flag_i = 1, target 0x40 -> next cycle if_valid_o = 0 and addr = 0x40. One cycle later if_pc_o = 0x40 with inst = ROM[16].
4. Misaligned target 0x43 -> addr = 0x40. Branch and pop in the same cycle -> popped entry never reappears and count = 0.
5. Wrap: branch to 0xFFFF_FFFC -> fetched PCs are 0xFFFF_FFFC then 0x0000_0000.
6. Assert rst_n_i mid-stream between clock edges -> outputs go to 0 immediately. After release, ce returns one edge later and fetch resumes at RESET_PC.
